core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle control sequencer for the RV32I core datapath. It steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB states. Decoder write/read enables pass through only in their legal stage. Data-memory accesses use a req/ack handshake, so wait-stated memory can replace the zero-latency DataMem. The block sits between InstrDecoder and the stateful datapath elements (ProgramCounter, RegFile, DataMem) and also provides run/halt/error control and a retired-instruction counter.

## Interface
- MEM_TIMEOUT, 15: maximum cycles spent in MEM without mem_ack before the error state; legal range 1–255.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; leaves IDLE
- resume  in  1  one-cycle pulse; leaves HALT
- halt_req  in  1  request to stop after the current instruction retires
- clr_err  in  1  one-cycle pulse; leaves ERR
- illegal  in  1  decoder flag for an unrecognised opcode (valid in DECODE)
- dec_we_regfile  in  1  decoder regfile write enable
- dec_we_datamem  in  1  decoder store enable
- dec_re_datamem  in  1  decoder load enable
- mem_ack  in  1  data memory completes the access this cycle
- ir_load  out  1  latch instrcode into the instruction register
- we_pc  out  1  PC update strobe
- we_regfile  out  1  gated regfile write
- we_datamem  out  1  gated store
- re_datamem  out  1  gated load
- mem_req  out  1  data memory request
- busy  out  1  state is FETCH..WB
- halted  out  1  state is HALT
- err  out  1  state is ERR
- state  out  3  current state encoding
- instret  out  32  retired-instruction count

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- IDLE: on start, go to FETCH. Other inputs are ignored.
- FETCH: ir_load=1. Go to DECODE.
- DECODE: if illegal=1, go to ERR. Otherwise go to EXEC.
- EXEC: the ALU settles.
  - If dec_we_datamem or dec_re_datamem is set, go to MEM.
  - Otherwise go to WB.
- MEM:
  - mem_req=1. we_datamem=dec_we_datamem and re_datamem=dec_re_datamem, held every MEM cycle.
  - On mem_ack, go to WB.
  - The wait counter increments on each MEM cycle without ack. If count = MEM_TIMEOUT−1 and there is no ack, go to ERR.
- WB:
  - we_regfile=dec_we_regfile, we_pc=1, instret+1 (wraps 0xFFFFFFFF→0).
  - If halt_pending, go to HALT and clear halt_pending. Otherwise go to FETCH.
- HALT: halted=1. On resume, go to FETCH.
- ERR: err=1, and the register is sticky. On clr_err, go to IDLE. instret is kept.
- halt_pending is set by halt_req in any of FETCH..WB. halt_req in IDLE, HALT, or ERR is ignored.
- Every gated strobe is 0 outside its stage. Decoder enables never reach the datapath in FETCH, DECODE, or EXEC.

## Timing
- Reset (asynchronous, immediate): state=IDLE and all outputs 0. instret=0, halt_pending=0, wait counter=0. A reset during MEM drops mem_req in the same instant.
- Outputs are Moore: a decode of the registered state ANDed with the dec_* inputs. No dependency on mem_ack.
- Latency:
  - Non-memory instruction: 4 cycles.
  - Memory instruction: 5 + N cycles, where N is the number of MEM cycles before mem_ack.
  - mem_ack in the first MEM cycle gives 5 cycles.
- Handshake:
  - mem_req rises on entry to MEM and holds until the ack cycle inclusive.
  - mem_ack outside MEM is ignored.
  - The wait counter clears on leaving MEM.
- Simultaneous events:
  - mem_ack in the timeout cycle: ack wins, go to WB.
  - halt_req in WB: that instruction retires, then go to HALT.
  - start outside IDLE, resume outside HALT, clr_err outside ERR: ignored.
- instret updates on the clock edge that ends WB, and is visible the next cycle.

## Structure
- Shared core_pkg holds:
  - state enum seq_state_t (3-bit, encodings above);
  - opcode constants;
  - INSTRET_W=32.
- Submodule mem_wait_timer: an 8-bit counter with clear, enable, and expire = (count == MEM_TIMEOUT−1) & enable. Everything else is one FSM with a registered state and a combinational output decode.

## Test plan
- ALU instruction sequence: reset, then start; dec_we_regfile=1 and no memory enables. Required:
  - state walks 1,2,3,5,1;
  - we_pc and we_regfile high only in WB;
  - instret reaches 3 after 12 cycles.
- Load with 2 wait cycles: dec_re_datamem=1, mem_ack on the 3rd MEM cycle. Required:
  - mem_req and re_datamem high for exactly 3 cycles;
  - WB follows;
  - total 7 cycles.
- Memory timeout: MEM_TIMEOUT=4, store, mem_ack never asserted. Required:
  - ERR after 4 MEM cycles, err=1, mem_req=0;
  - clr_err returns to IDLE with instret unchanged.
- Halt and resume: halt_req pulsed in DECODE. Required:
  - the instruction completes WB (instret+1), then state=6 and halted=1;
  - resume gives FETCH on the next cycle;
  - halt_req in HALT has no effect.
- Illegal opcode, then reset mid-MEM:
  - illegal=1 in DECODE goes to ERR with no WB strobe.
  - rst_n low during MEM zeroes all outputs asynchronously and gives state=0.
- instret wrap: force instret to 0xFFFFFFFF. One retired instruction gives 0x00000000.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle core: sequencer states, opcodes, counter widths.
package core_pkg;

    localparam int INSTRET_W = 32;
    localparam int WAIT_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } seq_state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    function automatic logic op_is_legal(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                          OP_LOAD, OP_STORE, OP_IMM, OP_REG};
    endfunction

    function automatic logic op_is_mem(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Sequencer-facing bundle: run control, decoder enables, data-memory handshake, datapath strobes, status.
interface core_sequencer_if;
    import core_pkg::*;

    logic                 start;
    logic                 resume;
    logic                 halt_req;
    logic                 clr_err;
    logic                 illegal;
    logic                 dec_we_regfile;
    logic                 dec_we_datamem;
    logic                 dec_re_datamem;
    logic                 mem_ack;
    logic                 mem_req;
    logic                 ir_load;
    logic                 we_pc;
    logic                 we_regfile;
    logic                 we_datamem;
    logic                 re_datamem;
    logic                 busy;
    logic                 halted;
    logic                 err;
    logic [2:0]           state;
    logic [INSTRET_W-1:0] instret;

    modport master (
        input  start, resume, halt_req, clr_err,
        input  illegal, dec_we_regfile, dec_we_datamem, dec_re_datamem,
        input  mem_ack,
        output mem_req, ir_load, we_pc, we_regfile, we_datamem, re_datamem,
        output busy, halted, err, state, instret
    );

    modport slave (
        output start, resume, halt_req, clr_err,
        output illegal, dec_we_regfile, dec_we_datamem, dec_re_datamem,
        output mem_ack,
        input  mem_req, ir_load, we_pc, we_regfile, we_datamem, re_datamem,
        input  busy, halted, err, state, instret
    );

endinterface

// File: rtl/core_sequencer_mem_wait_timer.sv
// Purpose: counts MEM cycles without ack and flags the last permitted one.
// Latency: expire is combinational from the registered count and en.
// Backpressure: none; clr has priority over en.
module mem_wait_timer
    import core_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WAIT_W'(1);
        end
    end

    assign expire = (count == LAST) & en;

endmodule

// File: rtl/core_sequencer.sv
// Purpose: steps each instruction through FETCH/DECODE/EXEC/[MEM]/WB and gates decoder enables per stage.
// Latency: 4 cycles per ALU instruction, 5+N for memory ops (N = MEM cycles before mem_ack).
// Backpressure: MEM holds mem_req until mem_ack; too many unacked cycles trap to ERR.
module core_sequencer
    import core_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    core_sequencer_if.master bus
);

    seq_state_t           state_q;
    seq_state_t           state_d;
    logic                 halt_pending_q;
    logic [INSTRET_W-1:0] instret_q;
    logic                 in_mem;
    logic                 running;
    logic                 wait_clr;
    logic                 wait_expire;

    assign in_mem   = (state_q == ST_MEM);
    assign running  = state_q inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB};
    assign wait_clr = ~in_mem | bus.mem_ack;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wait_clr),
        .en     (in_mem),
        .expire (wait_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = bus.illegal ? ST_ERR : ST_EXEC;
            ST_EXEC:   state_d = (bus.dec_we_datamem | bus.dec_re_datamem) ? ST_MEM : ST_WB;
            ST_MEM: begin
                // ack beats the timeout when both land in the same cycle
                if (bus.mem_ack) begin
                    state_d = ST_WB;
                end else if (wait_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB:     state_d = (halt_pending_q | bus.halt_req) ? ST_HALT : ST_FETCH;
            ST_HALT:   if (bus.resume) state_d = ST_FETCH;
            ST_ERR:    if (bus.clr_err) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ir_load    = 1'b0;
        bus.we_pc      = 1'b0;
        bus.we_regfile = 1'b0;
        bus.we_datamem = 1'b0;
        bus.re_datamem = 1'b0;
        bus.mem_req    = 1'b0;
        bus.halted     = 1'b0;
        bus.err        = 1'b0;
        case (state_q)
            ST_FETCH: bus.ir_load = 1'b1;
            ST_MEM: begin
                bus.mem_req    = 1'b1;
                bus.we_datamem = bus.dec_we_datamem;
                bus.re_datamem = bus.dec_re_datamem;
            end
            ST_WB: begin
                bus.we_pc      = 1'b1;
                bus.we_regfile = bus.dec_we_regfile;
            end
            ST_HALT:  bus.halted = 1'b1;
            ST_ERR:   bus.err    = 1'b1;
            default:  ;
        endcase
        bus.busy    = running;
        bus.state   = state_q;
        bus.instret = instret_q;
    end

    // A halt request outlives only the instruction it arrived during; leaving the run states drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_pending_q <= 1'b0;
        end else if (!running || (state_q == ST_WB)) begin
            halt_pending_q <= 1'b0;
        end else if (bus.halt_req) begin
            halt_pending_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (state_q == ST_WB) begin
            instret_q <= instret_q + INSTRET_W'(1);
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed table, multi-cycle corner sequences, then randomized run vs a reference model.
module tb_core_sequencer;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    core_sequencer_if sif();

    core_sequencer #(.MEM_TIMEOUT(TO)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       we_rf;
        logic       we_dm;
        logic       re_dm;
        logic       ack;
        logic [2:0] exp_st;
        logic [4:0] exp_strb;
        logic       exp_req;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    int          m_st;
    int          m_wait;
    bit          m_pend;
    longint      m_ret;

    function automatic vec_t v(input logic s, input logic rf, input logic dm, input logic rd,
                               input logic a, input logic [2:0] st, input logic [4:0] sb,
                               input logic rq);
        vec_t r;
        r.start = s; r.we_rf = rf; r.we_dm = dm; r.re_dm = rd; r.ack = a;
        r.exp_st = st; r.exp_strb = sb; r.exp_req = rq;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        sif.start = 0; sif.resume = 0; sif.halt_req = 0; sif.clr_err = 0;
        sif.illegal = 0; sif.dec_we_regfile = 0; sif.dec_we_datamem = 0;
        sif.dec_re_datamem = 0; sif.mem_ack = 0;
    endtask

    function automatic logic [4:0] strobes();
        return {sif.ir_load, sif.we_pc, sif.we_regfile, sif.we_datamem, sif.re_datamem};
    endfunction

    function automatic logic [11:0] dut_outs();
        return {sif.state, strobes(), sif.mem_req, sif.busy, sif.halted, sif.err};
    endfunction

    function automatic logic [11:0] model_outs();
        logic [11:0] o;
        o[11:9] = 3'(m_st);
        o[8]    = (m_st == 1);
        o[7]    = (m_st == 5);
        o[6]    = (m_st == 5) && sif.dec_we_regfile;
        o[5]    = (m_st == 4) && sif.dec_we_datamem;
        o[4]    = (m_st == 4) && sif.dec_re_datamem;
        o[3]    = (m_st == 4);
        o[2]    = (m_st >= 1) && (m_st <= 5);
        o[1]    = (m_st == 6);
        o[0]    = (m_st == 7);
        return o;
    endfunction

    // Called with the inputs that will be sampled on the coming edge.
    task automatic model_step();
        int nxt;
        nxt = m_st;
        case (m_st)
            0: if (sif.start) nxt = 1;
            1: nxt = 2;
            2: nxt = sif.illegal ? 7 : 3;
            3: nxt = (sif.dec_we_datamem || sif.dec_re_datamem) ? 4 : 5;
            4: if (sif.mem_ack) nxt = 5; else if (m_wait + 1 >= TO) nxt = 7;
            5: begin
                m_ret = (m_ret + 1) % 64'h1_0000_0000;
                nxt = (m_pend || sif.halt_req) ? 6 : 1;
            end
            6: if (sif.resume) nxt = 1;
            default: if (sif.clr_err) nxt = 0;
        endcase
        if (m_st == 5 || m_st == 0 || m_st >= 6) m_pend = 0;
        else if (sif.halt_req) m_pend = 1;
        m_wait = (m_st == 4 && nxt == 4) ? m_wait + 1 : 0;
        m_st = nxt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_inputs();
        rst_n = 0;
        #12;
        chk("reset_outs", 32'(dut_outs()), 32'h0);
        chk("reset_instret", sif.instret, 32'h0);
        rst_n = 1;
        @(posedge clk); #1;

        // three ALU instructions then a load with two wait cycles
        tbl.push_back(v(1, 1, 0, 0, 0, 3'd0, 5'b00000, 0));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(v(0, 1, 0, 0, 0, 3'd1, 5'b10000, 0));
            tbl.push_back(v(0, 1, 0, 0, 0, 3'd2, 5'b00000, 0));
            tbl.push_back(v(0, 1, 0, 0, 0, 3'd3, 5'b00000, 0));
            tbl.push_back(v(0, 1, 0, 0, 0, 3'd5, 5'b01100, 0));
        end
        tbl.push_back(v(0, 1, 0, 1, 0, 3'd1, 5'b10000, 0));
        tbl.push_back(v(0, 1, 0, 1, 1, 3'd2, 5'b00000, 0));
        tbl.push_back(v(0, 1, 0, 1, 1, 3'd3, 5'b00000, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 3'd4, 5'b00001, 1));
        tbl.push_back(v(0, 1, 0, 1, 0, 3'd4, 5'b00001, 1));
        tbl.push_back(v(0, 1, 0, 1, 1, 3'd4, 5'b00001, 1));
        tbl.push_back(v(0, 1, 0, 1, 0, 3'd5, 5'b01100, 0));

        foreach (tbl[i]) begin
            sif.start = tbl[i].start;
            sif.dec_we_regfile = tbl[i].we_rf;
            sif.dec_we_datamem = tbl[i].we_dm;
            sif.dec_re_datamem = tbl[i].re_dm;
            sif.mem_ack = tbl[i].ack;
            #1;
            chk($sformatf("tbl%0d_state", i), 32'(sif.state), 32'(tbl[i].exp_st));
            chk($sformatf("tbl%0d_strobes", i), 32'(strobes()), 32'(tbl[i].exp_strb));
            chk($sformatf("tbl%0d_mem_req", i), 32'(sif.mem_req), 32'(tbl[i].exp_req));
            if (i == 13) chk("instret_after_alu", sif.instret, 32'd3);
            step();
        end
        clr_inputs();
        #1;
        chk("after_load_state", 32'(sif.state), 32'd1);
        chk("after_load_instret", sif.instret, 32'd4);

        // store that is never acknowledged
        sif.dec_we_datamem = 1;
        step(); step(); step();
        for (int k = 0; k < TO; k++) begin
            chk($sformatf("to_mem%0d", k), {29'd0, sif.state, sif.mem_req, sif.we_datamem}, {29'd0, 3'd4, 2'b11});
            step();
        end
        chk("to_err_state", 32'(sif.state), 32'd7);
        chk("to_err_flags", {29'd0, sif.err, sif.mem_req, sif.we_datamem}, 32'b100);
        sif.clr_err = 1;
        step();
        clr_inputs();
        #1;
        chk("clr_err_state", 32'(sif.state), 32'd0);
        chk("clr_err_instret", sif.instret, 32'd4);

        // halt requested in DECODE, then resume
        sif.start = 1; sif.dec_we_regfile = 1;
        step();
        sif.start = 0;
        step();
        sif.halt_req = 1;
        #1;
        chk("halt_req_in_decode", 32'(sif.state), 32'd2);
        step();
        sif.halt_req = 0;
        step();
        chk("halt_wb_we_pc", {29'd0, sif.state, sif.we_pc}, {29'd0, 3'd5, 1'b1});
        step();
        chk("halt_state", {28'd0, sif.state, sif.halted}, {28'd0, 3'd6, 1'b1});
        chk("halt_instret", sif.instret, 32'd5);
        sif.halt_req = 1;
        step();
        sif.halt_req = 0;
        #1;
        chk("halt_req_in_halt", 32'(sif.state), 32'd6);
        sif.resume = 1;
        step();
        sif.resume = 0;
        #1;
        chk("resume_fetch", 32'(sif.state), 32'd1);

        // illegal opcode traps without any writeback
        step();
        sif.illegal = 1;
        #1;
        chk("illegal_decode_no_wb", {28'd0, sif.state, sif.we_pc}, {28'd0, 3'd2, 1'b0});
        step();
        sif.illegal = 0;
        #1;
        chk("illegal_err", {28'd0, sif.state, sif.err}, {28'd0, 3'd7, 1'b1});
        chk("illegal_instret", sif.instret, 32'd5);
        sif.clr_err = 1;
        step();
        clr_inputs();

        // asynchronous reset in the middle of MEM
        sif.start = 1;
        step();
        sif.start = 0; sif.dec_re_datamem = 1;
        step(); step(); step();
        #1;
        chk("pre_reset_mem", {30'd0, sif.mem_req, sif.re_datamem}, 32'b11);
        #1 rst_n = 0;
        #1;
        chk("async_reset_outs", 32'(dut_outs()), 32'h0);
        chk("async_reset_instret", sif.instret, 32'h0);
        #1 rst_n = 1;
        clr_inputs();
        step();

        // instret wrap
        sif.start = 1; sif.dec_we_regfile = 1;
        step();
        sif.start = 0;
        force u_dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release u_dut.instret_q;
        #1;
        chk("wrap_preload", sif.instret, 32'hFFFF_FFFF);
        step(); step(); step();
        chk("wrap_wb", 32'(sif.state), 32'd5);
        step();
        chk("wrap_instret", sif.instret, 32'h0);

        // randomized run against the reference model
        clr_inputs();
        #1 rst_n = 0;
        #2 rst_n = 1;
        step();
        m_st = 0; m_wait = 0; m_pend = 0; m_ret = 0;
        for (int c = 0; c < 3000; c++) begin
            sif.start          = ($urandom_range(0, 3) == 0);
            sif.resume         = ($urandom_range(0, 3) == 0);
            sif.clr_err        = ($urandom_range(0, 3) == 0);
            sif.halt_req       = ($urandom_range(0, 9) == 0);
            sif.illegal        = ($urandom_range(0, 9) == 0);
            sif.dec_we_regfile = 1'($urandom_range(0, 1));
            sif.dec_we_datamem = ($urandom_range(0, 3) == 0);
            sif.dec_re_datamem = ($urandom_range(0, 3) == 0);
            sif.mem_ack        = ($urandom_range(0, 2) == 0);
            #1;
            chk($sformatf("rand%0d_outs", c), 32'(dut_outs()), 32'(model_outs()));
            chk($sformatf("rand%0d_instret", c), sif.instret, m_ret[31:0]);
            model_step();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
